// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit: pipelined add/sub with valid/ready flow control and overflow policy; define ADDER_SATURATE_EN to enable saturation
module adder_pipe_nbit #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [1:0]       ovf_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  localparam int C = WIDTH / STAGES;
  logic             adv;
  logic [WIDTH-1:0] bx;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign bx       = b ^ {WIDTH{sub}};
  if (WIDTH < 2 || STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad
    $error("adder_pipe_nbit: WIDTH must be >= 2 and a multiple of STAGES");
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int HW = WIDTH - k * C;
    logic               v_i;
    logic               c_i;
    logic [1:0]         m_i;
    logic [HW-1:0]      ah_i;
    logic [HW-1:0]      bh_i;
    logic [C:0]         r;
    logic [(k+1)*C-1:0] s_d;
    assign r = {1'b0, ah_i[C-1:0]} + {1'b0, bh_i[C-1:0]} + {{C{1'b0}}, c_i};
    if (k == 0) begin : g_src
      assign v_i  = in_valid;
      assign c_i  = sub;
      assign m_i  = ovf_mode;
      assign ah_i = a;
      assign bh_i = bx;
      assign s_d  = r[C-1:0];
    end else begin : g_src
      assign v_i  = g_stg[k-1].g_reg.v_q;
      assign c_i  = g_stg[k-1].g_reg.c_q;
      assign m_i  = g_stg[k-1].g_reg.m_q;
      assign ah_i = g_stg[k-1].g_reg.ah_q;
      assign bh_i = g_stg[k-1].g_reg.bh_q;
      assign s_d  = {r[C-1:0], g_stg[k-1].g_reg.s_q};
    end
    if (k < STAGES - 1) begin : g_reg
      logic               v_q;
      logic               c_q;
      logic [1:0]         m_q;
      logic [HW-C-1:0]    ah_q;
      logic [HW-C-1:0]    bh_q;
      logic [(k+1)*C-1:0] s_q;
      // carry the partial sum, chunk carry and still-unused operand bits forward
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          v_q  <= 1'b0;
          c_q  <= 1'b0;
          m_q  <= '0;
          ah_q <= '0;
          bh_q <= '0;
          s_q  <= '0;
        end else if (adv) begin
          v_q  <= v_i;
          c_q  <= r[C];
          m_q  <= m_i;
          ah_q <= ah_i[HW-1:C];
          bh_q <= bh_i[HW-1:C];
          s_q  <= s_d;
        end
    end else begin : g_out
      logic             ovf_d;
      logic [WIDTH-1:0] sum_d;
      logic             v_q;
      logic             c_q;
      logic             o_q;
      logic [WIDTH-1:0] s_q;
      assign ovf_d = (ah_i[C-1] == bh_i[C-1]) && (r[C-1] != ah_i[C-1]);
`ifdef ADDER_SATURATE_EN
      assign sum_d = (!ovf_d || m_i[0] == m_i[1]) ? s_d :
                     m_i[0] ? '0 : {ah_i[C-1], {(WIDTH-1){!ah_i[C-1]}}};
`else
      assign sum_d = (ovf_d && m_i[0] != m_i[1]) ? '0 : s_d;
`endif
      // result register: policy-adjusted sum with raw arithmetic flags
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          o_q <= 1'b0;
          s_q <= '0;
        end else if (adv) begin
          v_q <= v_i;
          c_q <= r[C];
          o_q <= ovf_d;
          s_q <= sum_d;
        end
    end
  end
  assign out_valid = g_stg[STAGES-1].g_out.v_q;
  assign sum       = g_stg[STAGES-1].g_out.s_q;
  assign carry     = g_stg[STAGES-1].g_out.c_q;
  assign overflow  = g_stg[STAGES-1].g_out.o_q;
endmodule

// File: tb/tb_adder_pipe_nbit.sv
// tb_adder_pipe_nbit: directed self-checking bench for adder_pipe_nbit (WIDTH=8, STAGES=2)
module tb_adder_pipe_nbit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       sub = 1'b0;
  logic [1:0] ovf_mode = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic       carry;
  logic       overflow;
  logic [7:0] sum;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  int         sent = 0;
  int         got = 0;
`ifdef ADDER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  adder_pipe_nbit #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .ovf_mode(ovf_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                    input logic ts, input logic [1:0] tm,
                    input logic [7:0] es, input logic ec, input logic eo);
    a = ta; b = tb_v; sub = ts; ovf_mode = tm; in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_c"}, carry, ec);
    chk({tag, "_o"}, overflow, eo);
  endtask

  initial begin
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c", carry, 0);
    chk("rst_o", overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_rdy", in_ready, 1);

    op("add_wrap",  8'h7F, 8'h01, 1'b0, 2'b00, 8'h80, 1'b0, 1'b1);
    op("add_zero",  8'h7F, 8'h01, 1'b0, 2'b01, 8'h00, 1'b0, 1'b1);
    op("add_sat",   8'h7F, 8'h01, 1'b0, 2'b10, SAT ? 8'h7F : 8'h00, 1'b0, 1'b1);
    op("add_rsv",   8'h7F, 8'h01, 1'b0, 2'b11, 8'h80, 1'b0, 1'b1);
    op("sub_sat",   8'h80, 8'h01, 1'b1, 2'b10, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1);
    op("sub_wrap",  8'h05, 8'h07, 1'b1, 2'b00, 8'hFE, 1'b0, 1'b0);
    op("uwrap_00",  8'hFF, 8'h01, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    op("uwrap_01",  8'hFF, 8'h01, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0);
    op("uwrap_10",  8'hFF, 8'h01, 1'b0, 2'b10, 8'h00, 1'b1, 1'b0);
    op("neg_sat",   8'h80, 8'h80, 1'b0, 2'b10, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1);
    op("sub_pos",   8'h7F, 8'hFF, 1'b1, 2'b10, SAT ? 8'h7F : 8'h00, 1'b0, 1'b1);
    op("chunk_cy",  8'h0F, 8'h01, 1'b0, 2'b01, 8'h10, 1'b0, 1'b0);
    op("sub_eq",    8'h33, 8'h33, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);

    @(posedge clk); #1;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 6);
      in_valid = sent < 6;
      a = 8'(sent * 37 + 5);
      b = 8'(sent * 11 + 3);
      sub = sent[0];
      ovf_mode = 2'b00;
      #1;
      if (!out_ready) begin
        chk("stall_rdy", in_ready, 0);
        chk("stall_vld", out_valid, 1);
        chk("stall_sum", sum, q.size() > 0 ? q[0] : 8'hXX);
      end
      if (out_valid && out_ready) begin
        chk("stream_sum", sum, q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(sub ? 8'(a - b) : 8'(a + b));
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_cnt", got, 6);
    chk("stream_q", q.size(), 0);

    a = 8'h10; b = 8'h01; sub = 1'b0; ovf_mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_vld", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", out_valid, 0);
    end
    op("post_rst", 8'h0F, 8'h01, 1'b0, 2'b00, 8'h10, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
